// File: rtl/stepper_pll_pkg.sv
// rtl/stepper_pll_pkg.sv - shared types and defaults for the PLL reset sequencer
package stepper_pll_pkg;

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int DEF_RST_HOLD_CYCLES     = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 100000;
    localparam int DEF_MAX_RETRIES         = 3;
    localparam int DEF_RETRY_W             = 2;
    localparam int LOCK_LOSS_W             = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The counter only ever reaches max_val-1, so clog2(max_val) bits suffice.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// rtl/bit_sync_2ff.sv - async-reset two-flop single-bit synchronizer
module bit_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/stepper_pll_reset_sequencer.sv
// rtl/stepper_pll_reset_sequencer.sv - PLL reset, lock qualification and system reset release
module stepper_pll_reset_sequencer
    import stepper_pll_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int RETRY_W             = DEF_RETRY_W
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   soft_reset,
    output logic                   pll_rst,
    output logic                   sys_rst_n,
    output logic                   ready,
    output logic                   fault,
    output logic [RETRY_W-1:0]     retry_cnt,
    output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

    localparam int CNT_W = cnt_width(max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                          LOCK_TIMEOUT_CYCLES));
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t     state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               loss_inc;
    logic               locked_s;

    bit_sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        loss_inc  = 1'b0;
        if (soft_reset) begin
            state_nxt = HOLD;
            retry_nxt = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Lock wins over a timeout landing on the same cycle.
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_nxt = retry_cnt + 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = FAULT;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt = HOLD;
                        loss_inc  = 1'b1;
                    end
                end
                FAULT: ;
                default: state_nxt = HOLD;
            endcase
        end
    end

    // A soft reset restarts HOLD timing even when already in HOLD.
    always_comb begin
        cnt_nxt = cnt;
        if (soft_reset || (state_nxt != state)) begin
            cnt_nxt = '0;
        end else if (state == HOLD || state == WAIT_LOCK || state == STABLE) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HOLD;
            cnt           <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            if (loss_inc && (lock_loss_cnt != '1)) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
            pll_rst   <= (state_nxt == HOLD) || (state_nxt == FAULT);
            sys_rst_n <= (state_nxt == RUN);
            ready     <= (state_nxt == RUN);
            fault     <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_stepper_pll_reset_sequencer.sv
// tb/tb_stepper_pll_reset_sequencer.sv - model-checked bench for stepper_pll_reset_sequencer
module tb_stepper_pll_reset_sequencer;

    localparam int RST_HOLD    = 4;
    localparam int STABLE_N    = 8;
    localparam int TIMEOUT     = 32;
    localparam int MAX_RETRIES = 2;
    localparam int RETRY_W     = 2;

    logic               refclk     = 1'b0;
    logic               rst_n      = 1'b1;
    logic               pll_locked = 1'b0;
    logic               soft_reset = 1'b0;
    logic               pll_rst;
    logic               sys_rst_n;
    logic               ready;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;
    logic [7:0]         lock_loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;
    bit cmp_en   = 1'b0;

    always #5 refclk = ~refclk;

    stepper_pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (RST_HOLD),
        .LOCK_STABLE_CYCLES  (STABLE_N),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (MAX_RETRIES),
        .RETRY_W             (RETRY_W)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .soft_reset    (soft_reset),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp);
    endtask

    // Reference model: phase plus the age of that phase, lock seen through a 2-deep delay line.
    localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;
    int       m_phase = P_HOLD;
    int       m_age   = 0;
    int       m_retry = 0;
    int       m_loss  = 0;
    bit [1:0] m_sync  = 2'b00;

    always @(posedge refclk or negedge rst_n) begin
        int nxt;
        bit lk;
        if (!rst_n) begin
            m_phase = P_HOLD;
            m_age   = 0;
            m_retry = 0;
            m_loss  = 0;
            m_sync  = 2'b00;
        end else begin
            lk  = m_sync[1];
            nxt = m_phase;
            if (soft_reset) begin
                nxt     = P_HOLD;
                m_retry = 0;
            end else if (m_phase == P_HOLD) begin
                if (m_age + 1 >= RST_HOLD) nxt = P_WAIT;
            end else if (m_phase == P_WAIT) begin
                if (lk) nxt = P_STABLE;
                else if (m_age + 1 >= TIMEOUT) begin
                    if (m_retry < MAX_RETRIES) begin
                        m_retry++;
                        nxt = P_HOLD;
                    end else nxt = P_FAULT;
                end
            end else if (m_phase == P_STABLE) begin
                if (!lk) nxt = P_WAIT;
                else if (m_age + 1 >= STABLE_N) begin
                    nxt     = P_RUN;
                    m_retry = 0;
                end
            end else if (m_phase == P_RUN) begin
                if (!lk) begin
                    nxt    = P_HOLD;
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                end
            end
            m_age   = (soft_reset || nxt != m_phase) ? 0 : m_age + 1;
            m_phase = nxt;
            m_sync  = {m_sync[0], pll_locked};
        end
    end

    function automatic logic [13:0] model_out();
        logic pr, sr, ft;
        pr = (m_phase == P_HOLD) || (m_phase == P_FAULT);
        sr = (m_phase == P_RUN);
        ft = (m_phase == P_FAULT);
        return {pr, sr, sr, ft, RETRY_W'(m_retry), 8'(m_loss)};
    endfunction

    always @(negedge refclk) begin
        if (cmp_en)
            check("model", {pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt}, model_out());
    end

    task automatic tick();
        @(posedge refclk);
        #1;
        edge_no++;
    endtask

    task automatic run_to(input int e);
        while (edge_no < e) tick();
    endtask

    // Edge 0 still sees reset; rst_n releases 1 time unit after it.
    task automatic do_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        repeat (3) @(posedge refclk);
        @(posedge refclk);
        #1;
        rst_n   = 1'b1;
        edge_no = 0;
    endtask

    task automatic wait_ready(input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (ready !== val && n < budget) begin
            tick();
            n++;
        end
        check(name, ready, val);
    endtask

    initial begin
        int falls;
        int fault_low;
        logic prev;
        #1;
        cmp_en = 1'b1;

        // Normal bring-up
        do_reset();
        check("reset_pll_rst", pll_rst, 1);
        check("reset_sys_rst_n", sys_rst_n, 0);
        check("reset_loss", lock_loss_cnt, 0);
        run_to(3);  check("t1_pll_rst_e3", pll_rst, 1);
        run_to(4);  check("t1_pll_rst_e4", pll_rst, 0);
        run_to(10); pll_locked = 1'b1;
        run_to(20); check("t1_sys_rst_n_e20", sys_rst_n, 0);
        run_to(21); check("t1_sys_rst_n_e21", sys_rst_n, 1);
        check("t1_ready_e21", ready, 1);

        // Never locks
        do_reset();
        falls = 0;
        prev  = pll_rst;
        for (int e = 1; e <= 108; e++) begin
            tick();
            if (prev && !pll_rst) falls++;
            prev = pll_rst;
            if (e == 35)  check("t2_retry_e35", retry_cnt, 0);
            if (e == 36)  check("t2_retry_e36", retry_cnt, 1);
            if (e == 72)  check("t2_retry_e72", retry_cnt, 2);
            if (e == 107) check("t2_fault_e107", fault, 0);
        end
        check("t2_fault_e108", fault, 1);
        check("t2_pll_rst_e108", pll_rst, 1);
        check("t2_hold_pulses", falls, 3);
        fault_low = 0;
        repeat (200) begin
            tick();
            if (fault !== 1'b1) fault_low++;
        end
        check("t2_fault_sticky", fault_low, 0);
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("t5_fault_cleared", fault, 0);
        check("t5_retry_cleared", retry_cnt, 0);
        check("t5_pll_rst_hold", pll_rst, 1);

        // Lock flicker in STABLE, lock loss in RUN, soft reset colliding with loss
        do_reset();
        run_to(10); pll_locked = 1'b1;
        run_to(15); pll_locked = 1'b0;
        run_to(18); pll_locked = 1'b1;
        check("t3_retry_unchanged", retry_cnt, 0);
        run_to(21); check("t3_no_release_e21", ready, 0);
        run_to(28); check("t3_sys_rst_n_e28", sys_rst_n, 0);
        run_to(29); check("t3_sys_rst_n_e29", sys_rst_n, 1);
        run_to(35); pll_locked = 1'b0;
        run_to(37); check("t4_sys_rst_n_e37", sys_rst_n, 1);
        run_to(38); check("t4_sys_rst_n_e38", sys_rst_n, 0);
        check("t4_pll_rst_e38", pll_rst, 1);
        check("t4_loss_e38", lock_loss_cnt, 1);
        run_to(40); pll_locked = 1'b1;
        run_to(50); check("t4_sys_rst_n_e50", sys_rst_n, 0);
        run_to(51); check("t4_sys_rst_n_e51", sys_rst_n, 1);
        run_to(55); pll_locked = 1'b0;
        run_to(57); soft_reset = 1'b1;
        run_to(58); soft_reset = 1'b0;
        check("t5_pll_rst_e58", pll_rst, 1);
        check("t5_sys_rst_n_e58", sys_rst_n, 0);
        check("t5_loss_e58", lock_loss_cnt, 1);

        // Async reset mid-STABLE
        run_to(60); pll_locked = 1'b1;
        run_to(66); check("t6_in_stable", pll_rst, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_pll_rst", pll_rst, 1);
        check("t6_sys_rst_n", sys_rst_n, 0);
        check("t6_ready", ready, 0);
        check("t6_fault", fault, 0);
        check("t6_retry", retry_cnt, 0);
        check("t6_loss", lock_loss_cnt, 0);
        @(posedge refclk);
        #1;
        rst_n   = 1'b1;
        edge_no = 0;

        // Lock-loss saturation
        for (int i = 0; i < 256; i++) begin
            wait_ready(1'b1, 100, "sat_up");
            pll_locked = 1'b0;
            wait_ready(1'b0, 10, "sat_down");
            pll_locked = 1'b1;
        end
        check("t6_loss_saturated", lock_loss_cnt, 255);

        // Randomized lock behaviour, soft resets and async resets against the model
        for (int seg = 0; seg < 150; seg++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 80)) begin
                soft_reset = ($urandom_range(0, 99) == 0);
                tick();
            end
            soft_reset = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                #2;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
